// File: rtl/bpu_pkg.sv
// rtl/bpu_pkg.sv - shared opcodes, counter type and helpers for the branch predictor
package bpu_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } cnt_t;

    function automatic cnt_t sat_inc(cnt_t c);
        case (c)
            CNT_SNT: return CNT_WNT;
            CNT_WNT: return CNT_WT;
            default: return CNT_ST;
        endcase
    endfunction

    function automatic cnt_t sat_dec(cnt_t c);
        case (c)
            CNT_ST:  return CNT_WT;
            CNT_WT:  return CNT_WNT;
            default: return CNT_SNT;
        endcase
    endfunction

    // x1 (ra) and x5 (t0) are the link registers for call/return detection
    function automatic logic is_link(logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

endpackage

// File: rtl/bpu_if.sv
// rtl/bpu_if.sv - fetch-side and EX-side signal bundle of the branch predictor
interface bpu_if #(
    parameter int PC_W = 32
) ();
    logic            valid_i;
    logic [31:0]     inst_i;
    logic [PC_W-1:0] pc_i;
    logic            pred_taken_o;
    logic [PC_W-1:0] pred_pc_o;
    logic            upd_valid_i;
    logic [PC_W-1:0] upd_pc_i;
    logic            upd_taken_i;
    logic            flush_i;

    modport master (
        output valid_i, inst_i, pc_i, upd_valid_i, upd_pc_i, upd_taken_i, flush_i,
        input  pred_taken_o, pred_pc_o
    );

    modport slave (
        input  valid_i, inst_i, pc_i, upd_valid_i, upd_pc_i, upd_taken_i, flush_i,
        output pred_taken_o, pred_pc_o
    );
endinterface

// File: rtl/bpu_ras.sv
// rtl/bpu_ras.sv - circular return-address stack with flush
module bpu_ras #(
    parameter int RAS_DEPTH = 4,
    parameter int DATA_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    input  logic              flush,
    output logic [DATA_W-1:0] top,
    output logic              empty
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    logic [DATA_W-1:0] entries_q [RAS_DEPTH];
    logic [DATA_W-1:0] entries_d [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  top_idx;

    // ptr_q is the next free slot; the newest entry sits just below it
    assign top_idx = ptr_q - PTR_ONE;
    assign top     = entries_q[top_idx];
    assign empty   = (cnt_q == '0);

    // next-state: flush wins, then replace-top, push (overwrites oldest when full), pop
    always_comb begin
        entries_d = entries_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        if (flush) begin
            ptr_d = '0;
            cnt_d = '0;
        end else if (push && pop && !empty) begin
            entries_d[top_idx] = push_data;
        end else if (push) begin
            entries_d[ptr_q] = push_data;
            ptr_d            = ptr_q + PTR_ONE;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (pop && !empty) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    // state registers with synchronous reset clearing entries
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            entries_q <= entries_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: rtl/bpu.sv
// rtl/bpu.sv - dynamic branch predictor: BHT direction plus return-address stack
module bpu
    import bpu_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int RAS_DEPTH = 4,
    parameter int BHT_EN    = 1
) (
    input  logic  clk_i,
    input  logic  rst_n_i,
    bpu_if.slave  bus
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [PC_W-1:0] imm_b, imm_j, imm_i, pc_plus4, ras_top;
    logic            is_br, is_jal, is_jalr, is_ret;
    logic            ras_push, ras_pop, ras_empty, br_taken;
    logic [IDX_W-1:0] pred_idx, upd_idx;
    logic [1:0]      pred_cnt;
    cnt_t            bht_q [BHT_DEPTH];
    cnt_t            bht_d [BHT_DEPTH];
    logic            unused_upd_bits;

    assign opcode   = bus.inst_i[6:0];
    assign rd       = bus.inst_i[11:7];
    assign rs1      = bus.inst_i[19:15];
    assign imm_b    = {{(PC_W-13){bus.inst_i[31]}}, bus.inst_i[31], bus.inst_i[7],
                       bus.inst_i[30:25], bus.inst_i[11:8], 1'b0};
    assign imm_j    = {{(PC_W-21){bus.inst_i[31]}}, bus.inst_i[31], bus.inst_i[19:12],
                       bus.inst_i[20], bus.inst_i[30:21], 1'b0};
    assign imm_i    = {{(PC_W-12){bus.inst_i[31]}}, bus.inst_i[31:20]};
    assign pc_plus4 = bus.pc_i + PC_W'(4);

    assign is_br    = (opcode == OP_BRANCH);
    assign is_jal   = (opcode == OP_JAL);
    assign is_jalr  = (opcode == OP_JALR);
    assign is_ret   = is_jalr && is_link(rs1) && (rs1 != rd);
    assign ras_push = bus.valid_i && (is_jal || is_jalr) && is_link(rd);
    assign ras_pop  = bus.valid_i && is_ret;

    assign pred_idx = bus.pc_i[IDX_W+1:2];
    assign upd_idx  = bus.upd_pc_i[IDX_W+1:2];
    assign pred_cnt = bht_q[pred_idx];
    assign br_taken = (BHT_EN != 0) ? pred_cnt[1] : imm_b[PC_W-1];
    assign unused_upd_bits = ^{bus.upd_pc_i[PC_W-1:IDX_W+2], bus.upd_pc_i[1:0]};

    // zero-latency next-PC prediction from the current (pre-update) state
    always_comb begin
        bus.pred_taken_o = 1'b0;
        bus.pred_pc_o    = pc_plus4;
        if (bus.valid_i) begin
            if (is_br && br_taken) begin
                bus.pred_taken_o = 1'b1;
                bus.pred_pc_o    = bus.pc_i + imm_b;
            end else if (is_jal) begin
                bus.pred_taken_o = 1'b1;
                bus.pred_pc_o    = bus.pc_i + imm_j;
            end else if (is_ret && !ras_empty) begin
                bus.pred_taken_o = 1'b1;
                bus.pred_pc_o    = ras_top;
            end
        end
    end

    // BHT training from resolved branches; flush does not touch it
    always_comb begin
        bht_d = bht_q;
        if (bus.upd_valid_i) begin
            bht_d[upd_idx] = bus.upd_taken_i ? sat_inc(bht_q[upd_idx])
                                             : sat_dec(bht_q[upd_idx]);
        end
    end

    // BHT counters start weakly not-taken
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= CNT_WNT;
            end
        end else begin
            bht_q <= bht_d;
        end
    end

    bpu_ras #(
        .RAS_DEPTH (RAS_DEPTH),
        .DATA_W    (PC_W)
    ) u_ras (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus4),
        .flush     (bus.flush_i),
        .top       (ras_top),
        .empty     (ras_empty)
    );

endmodule

// File: doc/bpu.md
# bpu

Parametrised dynamic branch predictor for the fetch stage. It is the successor of the static decode-and-predict block. Each cycle it decodes the fetched instruction and predicts the next PC using:
- a table of 2-bit saturating counters (BHT) for conditional branches;
- a return-address stack (RAS) for calls and returns.

Resolved branch outcomes from EX train the BHT. A flush from EX/WB resets the speculative RAS.

## Interface
Parameters:
- PC_W, 32: PC width.
- BHT_DEPTH, 64: number of 2-bit counters; power of two, at least 2.
- RAS_DEPTH, 4: return-stack entries; power of two, at least 2.
- BHT_EN, 1: 1 selects dynamic direction from the BHT. 0 selects static backward-taken/forward-not-taken (BTFN); the BHT is still instantiated but ignored.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_n_i  in  1  reset, synchronous, active-low.
- valid_i  in  1  inst_i/pc_i carry an instruction accepted by fetch this cycle.
- inst_i  in  32  fetched instruction.
- pc_i  in  PC_W  PC of inst_i.
- pred_taken_o  out  1  predicted redirect (branch taken, jal, or jalr).
- pred_pc_o  out  PC_W  predicted next PC.
- upd_valid_i  in  1  EX resolved a conditional branch this cycle.
- upd_pc_i  in  PC_W  PC of the resolved branch.
- upd_taken_i  in  1  actual branch outcome.
- flush_i  in  1  pipeline redirect (mispredict, trap, mret).

## Operation
Decode:
- Opcodes as in the core decoder: branch 1100011, jal 1101111, jalr 1100111.
- Immediates: B-type for branch, J-type for jal, I-type for jalr; all sign-extended to PC_W.
- Link registers are x1 and x5.

Prediction (combinational; only meaningful while valid_i=1):
- Branch with BHT_EN=1: taken iff the counter at index pc_i[log2(BHT_DEPTH)+1:2] has MSB=1.
- Branch with BHT_EN=0: taken iff imm is negative.
- Taken branch: pred_pc_o = pc_i+imm. Not-taken branch: pc_i+4.
- jal: always taken, pred_pc_o = pc_i+imm.
- jalr, return form (rs1 is a link register and rs1 != rd), RAS non-empty: taken, pred_pc_o = RAS top.
- jalr, RAS empty or not return form: pred_taken_o=0, pred_pc_o = pc_i+4. EX will redirect.
- Any other instruction, or valid_i=0: pred_taken_o=0, pred_pc_o = pc_i+4.
- All adds wrap modulo 2^PC_W.

RAS rules (state changes only when valid_i=1):
- Push pc_i+4 on: jal with rd a link register, or jalr with rd a link register.
- Pop on a jalr in return form.
- jalr with rd and rs1 both links and rs1 != rd: pop then push, i.e. the top entry is replaced. The prediction uses the old top.
- Full push: the RAS is circular; it overwrites the oldest entry and count stays at RAS_DEPTH.
- Empty pop: no state change.

BHT update (when upd_valid_i=1):
- Index is upd_pc_i[log2(BHT_DEPTH)+1:2].
- Taken increments the counter, saturating at 11. Not-taken decrements, saturating at 00.
- A same-cycle predict and update on the same index: the prediction uses the pre-update value.

Flush:
- flush_i=1 sets RAS count and pointer to 0 at the edge.
- Flush has priority over a same-cycle push or pop.
- The BHT is unaffected and the update is still applied.

## Timing
- Prediction latency 0 cycles: combinational from inst_i, pc_i, and the current state.
- Updates, pushes, pops and flush take effect at the next rising edge; visible from the following cycle.
- Reset state:
  - all counters 01 (weakly not-taken);
  - RAS count 0, pointer 0, entries 0;
  - with valid_i=0, outputs are pred_taken_o=0, pred_pc_o=pc_i+4.
- Reset has priority over flush, update and push/pop. Reset in the middle of a call sequence discards all RAS contents.

## Structure
- Shared package:
  - opcode constants;
  - 2-bit counter type with encodings SNT=00, WNT=01, WT=10, ST=11;
  - saturating-increment and saturating-decrement functions;
  - link-register test function.
- One sub-module, bpu_ras (parameter RAS_DEPTH), with ports push, pop, push_data, flush, top, empty.
- The BHT is a flop array inside bpu.

## Test plan
- Reset, then branch at pc 0x80000000 with imm +16 → not taken, pred_pc_o=0x80000004.
- Two taken updates at pc 0x80000010 (BHT_DEPTH=64), then fetch the same PC with imm -8 → taken, pred_pc_o=0x80000008. Three not-taken updates → counter 00, not taken.
- BHT_EN=0: branch with imm -4 → taken; branch with imm +4 → not taken, regardless of updates.
- jal ra at 0x100, then jalr x0,0(ra) → the jalr predicts 0x104 and the RAS is empty afterwards. With 5 nested calls (RAS_DEPTH=4) followed by 5 returns: the first 4 returns predict correctly, the 5th predicts pc+4 with taken=0.
- Push in the same cycle as flush_i → the RAS ends empty; the next return predicts pc+4.
- Same-cycle update and predict on index 3 with counter 01 and upd_taken_i=1 → predicts not-taken this cycle, taken the next cycle.
